// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: two-requester round-robin arbiter and sequencer around a
// single shared 16-bit, 8-op ALU. The block latches the winning command, runs
// it through the ALU and returns a registered, tagged result over a
// valid/ready response channel. At most one command is in flight at a time.
//
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   r0_* / r1_*            requester command channels (valid/ready, op, a, b)
//   rsp_valid/rsp_ready    response handshake
//   rsp_id                 requester that owns the response
//   rsp_data, rsp_cout     registered ALU result and carry
//   busy                   high whenever a command is in flight
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  when defined, requester 0 always wins contention.
//                          When undefined (default), contention alternates.
//
// alu opcode map (cout meaning in brackets):
//   000 i0 + i1 [carry]      001 i0 - i1 [borrow]
//   010 i0 & i1 [0]          011 i0 | i1 [0]
//   100 i0 ^ i1 [0]          101 ~i0     [0]
//   110 i0 << 1 [i0 msb]     111 i0 >> 1 [i0 lsb]

module alu (
  input  logic [2:0]  op,
  input  logic [15:0] i0,
  input  logic [15:0] i1,
  output logic [15:0] outp,
  output logic        cout
);

  logic [16:0] res;

  always_comb begin
    res = '0;
    case (op)
      3'b000:  res = {1'b0, i0} + {1'b0, i1};
      3'b001:  res = {1'b0, i0} - {1'b0, i1};
      3'b010:  res = {1'b0, i0 & i1};
      3'b011:  res = {1'b0, i0 | i1};
      3'b100:  res = {1'b0, i0 ^ i1};
      3'b101:  res = {1'b0, ~i0};
      3'b110:  res = {i0, 1'b0};
      default: res = {i0[0], 1'b0, i0[15:1]};
    endcase
  end

  assign outp = res[15:0];
  assign cout = res[16];

endmodule

module alu_rr_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [2:0]       r0_op,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [2:0]       r1_op,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cout,
  output logic             busy
);

  if (WIDTH != 16) begin : g_width_check
    $error("alu_rr_arbiter: WIDTH must be 16 to match alu");
  end

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             last_id;
  logic             win_id;
  logic             id_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [15:0]      alu_outp;
  logic             alu_cout;

  // With no requester valid the winner value is irrelevant; only one ready
  // can ever be high, so a handshake can only come from the winner.
  always_comb begin
    win_id = ~last_id;
    if (r0_valid && !r1_valid) begin
      win_id = 1'b0;
    end else if (r1_valid && !r0_valid) begin
      win_id = 1'b1;
    end else if (r0_valid && r1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      win_id = 1'b0;
`else
      win_id = ~last_id;
`endif
    end
  end

  assign r0_ready = (state == IDLE) && !win_id;
  assign r1_ready = (state == IDLE) &&  win_id;

  alu u_alu (
    .op   (op_q),
    .i0   (a_q[15:0]),
    .i1   (b_q[15:0]),
    .outp (alu_outp),
    .cout (alu_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_id   <= 1'b1;
      id_q      <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_cout  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (r0_valid && r0_ready) begin
            op_q    <= r0_op;
            a_q     <= r0_a;
            b_q     <= r0_b;
            id_q    <= 1'b0;
            last_id <= 1'b0;
            busy    <= 1'b1;
            state   <= EXEC;
          end else if (r1_valid && r1_ready) begin
            op_q    <= r1_op;
            a_q     <= r1_a;
            b_q     <= r1_b;
            id_q    <= 1'b1;
            last_id <= 1'b1;
            busy    <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_outp;
          rsp_cout  <= alu_cout;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
